// File: rtl/rf_pkg.sv
// Shared definitions for the register-file dump/load sequencer.
// Holds the default widths, the sequencer state encoding and the
// transfer-mode constants used by rf_dump_load and its testbench.
package rf_pkg;

    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int NREG = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DUMP,
        DRAIN,
        DONE
    } rf_seq_state_t;

    localparam logic MODE_DUMP = 1'b0;
    localparam logic MODE_LOAD = 1'b1;

endpackage

// File: rtl/rf_out_buf.sv
// One-entry output holding register for the DUMP byte stream.
// The entry is free when it is empty or is being handed off this cycle.
// A byte loaded while the entry is free becomes valid on the next cycle
// and stays stable until the consumer raises out_ready.
module rf_out_buf #(
    parameter int DW = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          load,
    input  logic [DW-1:0] load_dat,
    input  logic          drain,
    input  logic          out_ready,
    output logic          free,
    output logic [DW-1:0] out_dat,
    output logic          out_valid
);

    assign free = !out_valid || out_ready;

    // Capture a new byte when free; drop valid once the last byte is taken.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_dat   <= '0;
            out_valid <= 1'b0;
        end else if (load && free) begin
            out_dat   <= load_dat;
            out_valid <= 1'b1;
        end else if (drain && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_dump_load.sv
// Dump/load sequencer for the 8x8 register file port.
// LOAD writes consecutive registers from an input byte stream; DUMP reads
// consecutive registers out through a one-entry output buffer. Addresses
// wrap modulo the register count. Done pulses for one cycle at the end.
// Optional: define RF_DUMP_LOAD_CHECKSUM_EN to add the Chk output, a
// running XOR of every byte transferred since the last accepted Start.
module rf_dump_load
    import rf_pkg::*;
#(
    parameter int DW = rf_pkg::DW,
    parameter int AW = rf_pkg::AW
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Mode,
    input  logic [AW-1:0] FirstReg,
    input  logic [AW:0]   Count,
    input  logic [DW-1:0] InDat,
    input  logic          InValid,
    output logic          InReady,
    output logic [DW-1:0] OutDat,
    output logic          OutValid,
    input  logic          OutReady,
    output logic [AW-1:0] Ra,
    output logic          Wen,
    output logic [DW-1:0] Wdat,
    input  logic [DW-1:0] RdatA,
    output logic          Busy,
    output logic          Done
`ifdef RF_DUMP_LOAD_CHECKSUM_EN
    ,
    output logic [DW-1:0] Chk
`endif
);

    localparam logic [AW:0] REM_ONE = (AW+1)'(1);

    rf_seq_state_t state, state_next;
    logic [AW-1:0] addr, addr_next;
    logic [AW:0]   rem, rem_next;
    logic          buf_load;
    logic          buf_drain;
    logic          buf_free;

    rf_out_buf #(.DW(DW)) u_out_buf (
        .Clk       (Clk),
        .Reset     (Reset),
        .load      (buf_load),
        .load_dat  (RdatA),
        .drain     (buf_drain),
        .out_ready (OutReady),
        .free      (buf_free),
        .out_dat   (OutDat),
        .out_valid (OutValid)
    );

    assign Ra   = addr;
    assign Busy = (state != IDLE);
    assign Done = (state == DONE);

    // State, address and remaining-count registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            addr  <= '0;
            rem   <= '0;
        end else begin
            state <= state_next;
            addr  <= addr_next;
            rem   <= rem_next;
        end
    end

    // Next-state, address stepping, register-file write and stream control.
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_next = state;
        addr_next  = addr;
        rem_next   = rem;
        buf_load   = 1'b0;
        buf_drain  = 1'b0;
        InReady    = 1'b0;
        Wen        = 1'b0;
        Wdat       = '0;
        case (state)
            IDLE: begin
                if (Start) begin
                    addr_next = FirstReg;
                    rem_next  = Count;
                    if (Count == '0)
                        state_next = DONE;
                    else if (Mode == MODE_LOAD)
                        state_next = LOAD;
                    else
                        state_next = DUMP;
                end
            end
            LOAD: begin
                InReady = 1'b1;
                if (InValid) begin
                    Wen       = 1'b1;
                    Wdat      = InDat;
                    addr_next = addr + 1'b1;
                    rem_next  = rem - 1'b1;
                    if (rem == REM_ONE)
                        state_next = DONE;
                end
            end
            DUMP: begin
                if (buf_free) begin
                    buf_load  = 1'b1;
                    addr_next = addr + 1'b1;
                    rem_next  = rem - 1'b1;
                    if (rem == REM_ONE)
                        state_next = DRAIN;
                end
            end
            DRAIN: begin
                buf_drain = 1'b1;
                if (OutReady)
                    state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef RF_DUMP_LOAD_CHECKSUM_EN
    // Running XOR of written and captured bytes, cleared when a transfer starts.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            Chk <= '0;
        else if (state == IDLE && Start)
            Chk <= '0;
        else if (Wen)
            Chk <= Chk ^ InDat;
        else if (buf_load)
            Chk <= Chk ^ RdatA;
    end
`endif

endmodule

// File: tb/tb_rf_dump_load.sv
// Self-checking bench for rf_dump_load: a table of directed transfers,
// randomized transfers, and a hand-written reset-abort sequence. A small
// register file lives in the bench; a separate reference array tracks what
// the register file should hold, and expected streams come from it.
module tb_rf_dump_load;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic       Mode;
    logic [2:0] FirstReg;
    logic [3:0] Count;
    logic [7:0] InDat;
    logic       InValid;
    logic       InReady;
    logic [7:0] OutDat;
    logic       OutValid;
    logic       OutReady;
    logic [2:0] Ra;
    logic       Wen;
    logic [7:0] Wdat;
    logic [7:0] RdatA;
    logic       Busy;
    logic       Done;
`ifdef RF_DUMP_LOAD_CHECKSUM_EN
    logic [7:0] Chk;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] rf       [8];
    logic [7:0] model_rf [8];

    typedef struct {
        logic       mode;
        logic [2:0] first;
        logic [3:0] count;
        logic       ramp;
        logic [7:0] base;
        logic       vpat_en;
        logic [7:0] vpat;
        int         vprob;
        int         rprob;
        int         stall_first;
        logic       busy_start;
        int         done_at;
    } xfer_t;

    xfer_t vec [9];

    rf_dump_load dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Mode     (Mode),
        .FirstReg (FirstReg),
        .Count    (Count),
        .InDat    (InDat),
        .InValid  (InValid),
        .InReady  (InReady),
        .OutDat   (OutDat),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Ra       (Ra),
        .Wen      (Wen),
        .Wdat     (Wdat),
        .RdatA    (RdatA),
        .Busy     (Busy),
        .Done     (Done)
`ifdef RF_DUMP_LOAD_CHECKSUM_EN
        ,
        .Chk      (Chk)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Register file attached to the sequencer port.
    always @(posedge Clk) begin
        if (Wen)
            rf[Ra] <= Wdat;
    end
    assign RdatA = rf[Ra];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic xfer_t mk(input logic mode, input logic [2:0] first, input logic [3:0] count,
                                 input logic ramp, input logic [7:0] base,
                                 input logic vpat_en, input logic [7:0] vpat,
                                 input int vprob, input int rprob, input int stall_first,
                                 input logic busy_start, input int done_at);
        xfer_t x;
        x.mode = mode; x.first = first; x.count = count;
        x.ramp = ramp; x.base = base;
        x.vpat_en = vpat_en; x.vpat = vpat;
        x.vprob = vprob; x.rprob = rprob; x.stall_first = stall_first;
        x.busy_start = busy_start; x.done_at = done_at;
        return x;
    endfunction

    // Run one transfer and check every cycle against the expected transfer.
    task automatic run_xfer(input xfer_t x);
        logic [7:0] exp_q [$];
        logic [7:0] chk_exp;
        logic [7:0] prev_dat;
        logic [2:0] wa;
        int         sent, got, cyc, last_evt, stall_left;
        bit         done_seen, prev_stall, exp_wen;

        exp_q   = {};
        chk_exp = '0;
        if (x.mode == 1'b0)
            for (int i = 0; i < int'(x.count); i++)
                exp_q.push_back(model_rf[(int'(x.first) + i) % 8]);

        @(negedge Clk);
        Start = 1'b1; Mode = x.mode; FirstReg = x.first; Count = x.count;
        InValid = 1'b0; OutReady = 1'b0;
        #1;
        check("idle_busy", Busy, 0);
        @(negedge Clk);
        Start = 1'b0;

        sent = 0; got = 0; cyc = 1; last_evt = 0;
        stall_left = x.stall_first; done_seen = 0; prev_stall = 0; prev_dat = '0;
        while (!done_seen && cyc < 400) begin
            if (x.busy_start) begin
                Start    = 1'($urandom_range(1));
                Mode     = 1'($urandom_range(1));
                FirstReg = 3'($urandom_range(7));
                Count    = 4'($urandom_range(8));
            end
            if (x.vpat_en && cyc <= 8)
                InValid = x.vpat[cyc-1];
            else
                InValid = ($urandom_range(99) < x.vprob);
            InDat = x.ramp ? 8'(x.base + 8'(sent)) : 8'($urandom);
            if (OutValid && stall_left > 0) begin
                OutReady = 1'b0;
                stall_left--;
            end else begin
                OutReady = ($urandom_range(99) < x.rprob);
            end
            #1;

            exp_wen = x.mode && (sent < int'(x.count)) && InValid;
            check("in_ready", InReady, x.mode && (sent < int'(x.count)));
            check("wen", Wen, exp_wen);
            if (exp_wen) begin
                wa = 3'((int'(x.first) + sent) % 8);
                check("ra", Ra, wa);
                check("wdat", Wdat, InDat);
                model_rf[wa] = InDat;
                chk_exp ^= InDat;
                sent++;
                last_evt = cyc;
            end else begin
                check("wdat_idle", Wdat, 0);
            end

            if (!x.mode) begin
                check("out_valid", OutValid, (cyc >= 2) && (got < int'(x.count)));
                if (prev_stall && OutValid)
                    check("out_hold", OutDat, prev_dat);
                if (OutValid && OutReady && got < int'(x.count)) begin
                    check("out_dat", OutDat, exp_q[got]);
                    chk_exp ^= exp_q[got];
                    got++;
                    last_evt = cyc;
                end
                prev_stall = OutValid && !OutReady;
                prev_dat   = OutDat;
            end else begin
                check("out_valid_load", OutValid, 0);
            end

            if (Done) begin
                done_seen = 1;
                check("done_time", cyc, last_evt + 1);
                check("done_count", x.mode ? sent : got, x.count);
                if (x.done_at > 0)
                    check("done_lat", cyc, x.done_at);
`ifdef RF_DUMP_LOAD_CHECKSUM_EN
                check("chk", Chk, chk_exp);
`endif
            end
            check("busy", Busy, 1);
            @(negedge Clk);
            cyc++;
        end
        check("done_seen", done_seen, 1);
        Start = 1'b0; InValid = 1'b0; OutReady = 1'b0;
        #1;
        check("idle_after", Busy, 0);
        check("done_pulse", Done, 0);
        if (x.mode)
            for (int i = 0; i < 8; i++)
                check("rf_contents", rf[i], model_rf[i]);
    endtask

    initial begin
        xfer_t rx;

        vec[0] = mk(1'b1, 3'd0, 4'd8, 1'b1, 8'h10, 1'b0, 8'h00, 100, 100, 0, 1'b0, 9);
        vec[1] = mk(1'b1, 3'd0, 4'd8, 1'b1, 8'hA0, 1'b0, 8'h00, 100, 100, 0, 1'b0, 9);
        vec[2] = mk(1'b0, 3'd6, 4'd4, 1'b0, 8'h00, 1'b0, 8'h00, 100, 100, 0, 1'b0, 6);
        vec[3] = mk(1'b0, 3'd1, 4'd3, 1'b0, 8'h00, 1'b0, 8'h00, 100, 100, 5, 1'b0, 10);
        vec[4] = mk(1'b1, 3'd5, 4'd2, 1'b0, 8'h00, 1'b1, 8'b0000_1001, 100, 100, 0, 1'b0, 5);
        vec[5] = mk(1'b1, 3'd3, 4'd0, 1'b0, 8'h00, 1'b0, 8'h00, 100, 100, 0, 1'b1, 1);
        vec[6] = mk(1'b0, 3'd3, 4'd0, 1'b0, 8'h00, 1'b0, 8'h00, 100, 100, 0, 1'b0, 1);
        vec[7] = mk(1'b0, 3'd3, 4'd8, 1'b0, 8'h00, 1'b0, 8'h00, 100, 60, 0, 1'b1, -1);
        vec[8] = mk(1'b1, 3'd7, 4'd5, 1'b0, 8'h00, 1'b0, 8'h00, 50, 100, 0, 1'b1, -1);

        Reset = 1'b1; Start = 1'b0; Mode = 1'b0; FirstReg = '0; Count = '0;
        InDat = '0; InValid = 1'b0; OutReady = 1'b0;
        for (int i = 0; i < 8; i++) model_rf[i] = '0;

        repeat (2) @(negedge Clk);
        InValid = 1'b1;
        #1;
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_out_valid", OutValid, 0);
        check("rst_out_dat", OutDat, 0);
        check("rst_ra", Ra, 0);
        check("rst_in_ready", InReady, 0);
        check("rst_wen", Wen, 0);
        @(negedge Clk);
        InValid = 1'b0;
        Reset = 1'b0;

        for (int v = 0; v < 9; v++)
            run_xfer(vec[v]);

        for (int r = 0; r < 25; r++) begin
            rx = mk(1'($urandom_range(1)), 3'($urandom_range(7)), 4'($urandom_range(8)),
                    1'b0, 8'h00, 1'b0, 8'h00,
                    $urandom_range(30, 100), $urandom_range(30, 100), 0,
                    1'($urandom_range(1)), -1);
            run_xfer(rx);
        end

        // Reset in the middle of a LOAD after three bytes.
        @(negedge Clk);
        Start = 1'b1; Mode = 1'b1; FirstReg = 3'd0; Count = 4'd8;
        @(negedge Clk);
        Start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            InValid = 1'b1;
            InDat   = 8'(8'h50 + i);
            #1;
            check("abort_pre_wen", Wen, 1);
            model_rf[i] = InDat;
            @(negedge Clk);
        end
        InValid = 1'b1;
        InDat   = 8'hEE;
        Reset   = 1'b1;
        #1;
        check("abort_wen", Wen, 0);
        check("abort_in_ready", InReady, 0);
        check("abort_busy", Busy, 0);
        check("abort_done", Done, 0);
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("abort_no_done", Done, 0);
            check("abort_no_wen", Wen, 0);
            @(negedge Clk);
        end
        InValid = 1'b0;
        #1;
        for (int i = 0; i < 8; i++)
            check("abort_rf", rf[i], model_rf[i]);

        run_xfer(mk(1'b1, 3'd2, 4'd6, 1'b0, 8'h00, 1'b0, 8'h00, 80, 100, 0, 1'b0, -1));
        run_xfer(mk(1'b0, 3'd0, 4'd8, 1'b0, 8'h00, 1'b0, 8'h00, 100, 100, 0, 1'b0, 10));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
